// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the PIC priority resolver
// Contents: NUM_IR, ir_idx_t, trigger-mode and reset-pointer constants,
//           prio_rank() helper giving a request's rank under a rotation pointer.
package pic_pkg;

   localparam int NUM_IR = 8;

   typedef logic [2:0] ir_idx_t;

   localparam logic    LEVEL_TRIG   = 1'b1;
   localparam logic    EDGE_TRIG    = 1'b0;
   localparam ir_idx_t LP_RESET     = 3'd7;
   localparam ir_idx_t SPURIOUS_IDX = 3'd7;

   // Rank 0 is the highest priority: the IR right after the lowest-priority pointer.
   function automatic ir_idx_t prio_rank(ir_idx_t idx, ir_idx_t lp);
      return idx - lp - 3'd1;
   endfunction

endpackage

// File: rtl/pic_priority_resolver_if.sv
// rtl/pic_priority_resolver_if.sv - request/ack/command bundle between control logic and resolver
// Signals: ir_in, ltim, imr, aeoi, inta_first/second, eoi_cmd/specific/level,
//          rotate, set_priority, priority_level (to resolver);
//          int_request, interrupt_index, irr, isr, ack_done (from resolver).
// Modports: slave = resolver side, master = control/stimulus side.
interface pic_priority_resolver_if;
   import pic_pkg::*;

   logic [NUM_IR-1:0] ir_in;
   logic              ltim;
   logic [NUM_IR-1:0] imr;
   logic              aeoi;
   logic              inta_first;
   logic              inta_second;
   logic              eoi_cmd;
   logic              eoi_specific;
   ir_idx_t           eoi_level;
   logic              rotate;
   logic              set_priority;
   ir_idx_t           priority_level;
   logic              int_request;
   ir_idx_t           interrupt_index;
   logic [NUM_IR-1:0] irr;
   logic [NUM_IR-1:0] isr;
   logic              ack_done;

   modport slave (
      input  ir_in, ltim, imr, aeoi, inta_first, inta_second, eoi_cmd,
             eoi_specific, eoi_level, rotate, set_priority, priority_level,
      output int_request, interrupt_index, irr, isr, ack_done
   );

   modport master (
      output ir_in, ltim, imr, aeoi, inta_first, inta_second, eoi_cmd,
             eoi_specific, eoi_level, rotate, set_priority, priority_level,
      input  int_request, interrupt_index, irr, isr, ack_done
   );

endinterface

// File: rtl/pic_rot_prio_enc.sv
// rtl/pic_rot_prio_enc.sv - rotating priority encoder
// Ports: vec_i (request vector), lp_i (lowest-priority IR),
//        valid_o (any bit set), idx_o (highest-priority set bit).
module pic_rot_prio_enc
   import pic_pkg::*;
(
   input  logic [NUM_IR-1:0] vec_i,
   input  ir_idx_t           lp_i,
   output logic              valid_o,
   output ir_idx_t           idx_o
);

   logic [2*NUM_IR-1:0] dbl;
   logic [2*NUM_IR-1:0] sft;
   logic [3:0]          sh;
   logic [NUM_IR-1:0]   rot;
   ir_idx_t             pos;

   always_comb begin
      // Rotate so IR(lp+1) lands on bit 0; shift is 1..8.
      dbl = {vec_i, vec_i};
      sh  = {1'b0, lp_i} + 4'd1;
      sft = dbl >> sh;
      rot = sft[NUM_IR-1:0];

      pos = '0;
      for (int i = NUM_IR - 1; i >= 0; i--) begin
         if (rot[i]) pos = ir_idx_t'(i);
      end

      valid_o = |vec_i;
      idx_o   = pos + lp_i + 3'd1;
   end

endmodule

// File: rtl/pic_priority_resolver.sv
// rtl/pic_priority_resolver.sv - IRR/ISR holding, masking and fully-nested priority resolution
// Ports: clk, rst (sync active-high), bus (pic_priority_resolver_if.slave).
module pic_priority_resolver
   import pic_pkg::*;
(
   input logic                     clk,
   input logic                     rst,
   pic_priority_resolver_if.slave  bus
);

   logic [NUM_IR-1:0] ir_q;
   logic [NUM_IR-1:0] irr_q, irr_d;
   logic [NUM_IR-1:0] isr_q, isr_d;
   ir_idx_t           lp_q, lp_d;
   ir_idx_t           idx_q, idx_d;
   logic              req_q, req_d;
   logic              frozen_q, frozen_d;
   logic              ack_q, ack_d;

   logic [NUM_IR-1:0] cand;
   logic              win_v, hp_v;
   ir_idx_t           win_idx, hp_idx;
   logic              second_ok;
   logic              clr_v;
   ir_idx_t           clr_idx;

   assign cand = irr_q & ~bus.imr;

   pic_rot_prio_enc u_win_enc (
      .vec_i   (cand),
      .lp_i    (lp_q),
      .valid_o (win_v),
      .idx_o   (win_idx)
   );

   pic_rot_prio_enc u_hp_enc (
      .vec_i   (isr_q),
      .lp_i    (lp_q),
      .valid_o (hp_v),
      .idx_o   (hp_idx)
   );

   always_comb begin
      irr_d    = irr_q;
      isr_d    = isr_q;
      lp_d     = lp_q;
      idx_d    = idx_q;
      frozen_d = frozen_q;
      clr_v    = 1'b0;
      clr_idx  = hp_idx;

      // A second INTA only counts when it closes an open sequence and is not
      // coincident with a first INTA.
      second_ok = bus.inta_second & ~bus.inta_first & frozen_q;
      ack_d     = second_ok;

      if (bus.ltim == LEVEL_TRIG) begin
         irr_d = bus.ir_in;
      end else begin
         irr_d = (irr_q | (bus.ir_in & ~ir_q)) & bus.ir_in;
      end

      // EOI works on the pre-acknowledge ISR so a same-cycle set below wins.
      if (bus.eoi_cmd) begin
         if (bus.eoi_specific) begin
            clr_v   = 1'b1;
            clr_idx = bus.eoi_level;
         end else begin
            clr_v   = hp_v;
         end
      end
      if (clr_v) begin
         isr_d[clr_idx] = 1'b0;
         if (bus.rotate) lp_d = clr_idx;
      end

      if (second_ok) begin
         frozen_d = 1'b0;
         if (bus.aeoi) begin
            isr_d[idx_q] = 1'b0;
            if (bus.rotate) lp_d = idx_q;
         end
      end

      if (bus.inta_first) begin
         frozen_d = 1'b1;
         if (win_v) begin
            idx_d          = win_idx;
            isr_d[win_idx] = 1'b1;
            irr_d[win_idx] = 1'b0;
         end else begin
            idx_d = SPURIOUS_IDX;
         end
      end

      if (bus.set_priority) lp_d = bus.priority_level;

      req_d = ~frozen_d & win_v &
              (~hp_v | (prio_rank(win_idx, lp_q) < prio_rank(hp_idx, lp_q)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q     <= '0;
         irr_q    <= '0;
         isr_q    <= '0;
         lp_q     <= LP_RESET;
         idx_q    <= '0;
         req_q    <= 1'b0;
         frozen_q <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         ir_q     <= bus.ir_in;
         irr_q    <= irr_d;
         isr_q    <= isr_d;
         lp_q     <= lp_d;
         idx_q    <= idx_d;
         req_q    <= req_d;
         frozen_q <= frozen_d;
         ack_q    <= ack_d;
      end
   end

   assign bus.int_request     = req_q;
   assign bus.interrupt_index = idx_q;
   assign bus.irr             = irr_q;
   assign bus.isr             = isr_q;
   assign bus.ack_done        = ack_q;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// tb/tb_pic_priority_resolver.sv - scoreboard bench for pic_priority_resolver
module tb_pic_priority_resolver;
   import pic_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   chk_cnt = 0;
   int   err_cnt = 0;

   localparam int S_IRR = 0;
   localparam int S_ISR = 1;
   localparam int S_REQ = 2;
   localparam int S_IDX = 3;
   localparam int S_ACK = 4;

   typedef struct {
      string      tag;
      int         sel;
      logic [7:0] val;
   } exp_t;

   exp_t sb_q[$];

   pic_priority_resolver_if bus ();

   pic_priority_resolver dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] observe(input int sel);
      case (sel)
         S_IRR:   return bus.irr;
         S_ISR:   return bus.isr;
         S_REQ:   return {7'd0, bus.int_request};
         S_IDX:   return {5'd0, bus.interrupt_index};
         default: return {7'd0, bus.ack_done};
      endcase
   endfunction

   task automatic expect_out(input string tag, input int sel, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb_q.push_back(e);
   endtask

   // Advance one clock, then retire every expectation queued for this cycle.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.sel), e.val);
      end
   endtask

   initial begin
      bus.ir_in          = '0;
      bus.ltim           = EDGE_TRIG;
      bus.imr            = '0;
      bus.aeoi           = 1'b0;
      bus.inta_first     = 1'b0;
      bus.inta_second    = 1'b0;
      bus.eoi_cmd        = 1'b0;
      bus.eoi_specific   = 1'b0;
      bus.eoi_level      = '0;
      bus.rotate         = 1'b0;
      bus.set_priority   = 1'b0;
      bus.priority_level = '0;

      step(); step();
      rst = 1'b0;
      expect_out("rst_irr", S_IRR, 8'h00);
      expect_out("rst_isr", S_ISR, 8'h00);
      expect_out("rst_req", S_REQ, 8'h00);
      expect_out("rst_idx", S_IDX, 8'h00);
      expect_out("rst_ack", S_ACK, 8'h00);
      step();

      // Edge capture, two-cycle request latency, first acknowledge.
      bus.ir_in = 8'h24;
      expect_out("t1_irr_cap", S_IRR, 8'h24);
      expect_out("t1_req_lat1", S_REQ, 8'h00);
      step();
      expect_out("t1_req_lat2", S_REQ, 8'h01);
      step();
      bus.inta_first = 1'b1;
      expect_out("t1_idx", S_IDX, 8'h02);
      expect_out("t1_isr", S_ISR, 8'h04);
      expect_out("t1_irr", S_IRR, 8'h20);
      expect_out("t1_req_drop", S_REQ, 8'h00);
      step();
      bus.inta_first  = 1'b0;
      bus.inta_second = 1'b1;
      expect_out("t1_ack", S_ACK, 8'h01);
      step();
      bus.inta_second = 1'b0;
      expect_out("t1_ack_end", S_ACK, 8'h00);
      expect_out("t2_ir5_blocked", S_REQ, 8'h00);
      step();

      // Nesting: IR0 outranks in-service IR2.
      bus.ir_in = 8'h25;
      step();
      expect_out("t2_ir0_nest", S_REQ, 8'h01);
      step();

      // Non-specific EOI with rotation: lp becomes 2.
      bus.eoi_cmd = 1'b1;
      bus.rotate  = 1'b1;
      expect_out("t3_eoi_isr", S_ISR, 8'h00);
      step();
      bus.eoi_cmd = 1'b0;
      bus.rotate  = 1'b0;
      bus.ir_in   = 8'h00;
      step();
      expect_out("t3_irr_clr", S_IRR, 8'h00);
      expect_out("t3_req_clr", S_REQ, 8'h00);
      step();
      bus.ir_in = 8'h0A;
      step();
      expect_out("t3_req", S_REQ, 8'h01);
      step();
      bus.inta_first = 1'b1;
      expect_out("t3_idx_rot", S_IDX, 8'h03);
      expect_out("t3_isr", S_ISR, 8'h08);
      step();
      bus.inta_first  = 1'b0;
      bus.inta_second = 1'b1;
      expect_out("t3_ack", S_ACK, 8'h01);
      step();
      bus.inta_second  = 1'b0;
      bus.eoi_cmd      = 1'b1;
      bus.eoi_specific = 1'b1;
      bus.eoi_level    = 3'd3;
      expect_out("t3_spec_eoi", S_ISR, 8'h00);
      step();
      bus.eoi_cmd      = 1'b0;
      bus.eoi_specific = 1'b0;
      bus.ir_in        = 8'h00;
      step(); step();

      // AEOI, then set_priority beating the AEOI rotation for lp.
      bus.aeoi  = 1'b1;
      bus.ir_in = 8'h40;
      step();
      expect_out("t4_req", S_REQ, 8'h01);
      step();
      bus.inta_first = 1'b1;
      expect_out("t4_idx", S_IDX, 8'h06);
      expect_out("t4_isr_set", S_ISR, 8'h40);
      step();
      bus.inta_first     = 1'b0;
      bus.ir_in          = 8'h00;
      bus.inta_second    = 1'b1;
      bus.rotate         = 1'b1;
      bus.set_priority   = 1'b1;
      bus.priority_level = 3'd5;
      expect_out("t4_aeoi_isr", S_ISR, 8'h00);
      expect_out("t4_aeoi_ack", S_ACK, 8'h01);
      step();
      bus.inta_second  = 1'b0;
      bus.rotate       = 1'b0;
      bus.set_priority = 1'b0;
      step();
      bus.ir_in = 8'h60;
      step();
      expect_out("t4_req2", S_REQ, 8'h01);
      step();
      bus.inta_first = 1'b1;
      expect_out("t4_lp5_idx", S_IDX, 8'h06);
      step();
      bus.inta_first  = 1'b0;
      bus.inta_second = 1'b1;
      expect_out("t4_aeoi_isr2", S_ISR, 8'h00);
      step();
      bus.inta_second    = 1'b0;
      bus.set_priority   = 1'b1;
      bus.priority_level = 3'd7;
      bus.ir_in          = 8'h00;
      bus.aeoi           = 1'b0;
      step();
      bus.set_priority = 1'b0;
      step(); step();

      // Masking keeps IRR; unmasking raises the request; spurious INTA.
      bus.imr   = 8'hFF;
      bus.ir_in = 8'h01;
      step();
      expect_out("t5_mask_irr", S_IRR, 8'h01);
      expect_out("t5_mask_req", S_REQ, 8'h00);
      step();
      bus.imr = 8'h00;
      step();
      expect_out("t5_unmask_req", S_REQ, 8'h01);
      step();
      bus.ir_in = 8'h00;
      step();
      expect_out("t5_idle_req", S_REQ, 8'h00);
      step();
      bus.inta_first = 1'b1;
      expect_out("t5_spur_idx", S_IDX, 8'h07);
      expect_out("t5_spur_isr", S_ISR, 8'h00);
      step();
      bus.inta_first  = 1'b0;
      bus.inta_second = 1'b1;
      expect_out("t5_spur_ack", S_ACK, 8'h01);
      step();
      bus.inta_second = 1'b0;
      step();

      // Reset in the middle of an INTA sequence abandons it.
      bus.ir_in = 8'h10;
      step();
      expect_out("t6_req", S_REQ, 8'h01);
      step();
      bus.inta_first = 1'b1;
      expect_out("t6_isr", S_ISR, 8'h10);
      step();
      bus.inta_first = 1'b0;
      bus.ir_in      = 8'h00;
      rst            = 1'b1;
      expect_out("t6_rst_isr", S_ISR, 8'h00);
      expect_out("t6_rst_irr", S_IRR, 8'h00);
      expect_out("t6_rst_req", S_REQ, 8'h00);
      step();
      rst             = 1'b0;
      bus.inta_second = 1'b1;
      expect_out("t6_no_ack1", S_ACK, 8'h00);
      step();
      bus.inta_second = 1'b0;
      expect_out("t6_no_ack2", S_ACK, 8'h00);
      step();

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
